sata_command_fis_tx: RTL
========================

Name: sata_command_fis_tx

Overview:
- Downstream neighbour of the SATA DMA command sequencer. Consumes its command, strobe, LBA and sector-count outputs and returns the `sata_busy` signal it waits on.
- Builds a 5-dword Register Host-to-Device FIS and streams it to the transport layer with a valid/ready handshake.
- Retries on transport error, then holds busy until the device's Register Device-to-Host FIS reports BSY=0, or until a timeout.

Parameters:
- DEVICE_REG, 8'h40, device register byte (LBA mode) placed in DW1[31:24].
- MAX_RETRIES, 3, number of FIS re-sends allowed after a transport error.
- TIMEOUT_CYCLES, 32'd100000000, cycles to wait in WAIT_D2H before declaring a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sata_command  in  8  ATA command byte
- sata_execute_command_stb  in  1  one-cycle command launch strobe
- sata_lba  in  48  starting sector address
- sata_sector_count  in  16  sector count; 0 means 65536
- sata_busy  out  1  command in progress
- fis_data  out  32  FIS dword to transport
- fis_valid  out  1  fis_data valid
- fis_first  out  1  marks DW0
- fis_last  out  1  marks DW4
- fis_ready  in  1  transport accepts the current dword
- tx_ok  in  1  strobe: transport reports FIS delivered (R_OK)
- tx_err  in  1  strobe: transport reports FIS rejected (R_ERR/sync abort)
- d2h_stb  in  1  strobe: Register D2H FIS received
- d2h_status  in  8  D2H status byte
- d2h_error  in  8  D2H error byte
- cmd_done  out  1  one-cycle completion strobe
- cmd_error  out  1  valid with cmd_done: ERR bit, retry exhaustion, or timeout
- cmd_timeout  out  1  valid with cmd_done: completion caused by timeout
- cmd_status  out  8  last latched D2H status byte
- cmd_error_reg  out  8  last latched D2H error byte

Behaviour:

Reset
- While rst=0, all outputs are 0, state=IDLE, and the retry counter, timeout counter and dword index are all 0.
- Asserting reset mid-operation aborts immediately, with no cmd_done.

Latching and busy
- In IDLE, sata_execute_command_stb latches command, lba and count. The next cycle is state SEND, with sata_busy=1.
- A strobe received while not IDLE is ignored.
- sata_busy stays 1 through the cycle before cmd_done. It is 0 in the cycle cmd_done=1.

FIS layout (unused fields are 0)
- DW0 = {features 8'h00, command, 8'h80 (C bit set, PM port 0), 8'h27}.
- DW1 = {DEVICE_REG, lba[23:0]}.
- DW2 = {8'h00, lba[47:24]}.
- DW3 = {16'h0000, count}.
- DW4 = 32'h0.

SEND
- fis_valid=1 and fis_data=DW[idx]. fis_first = (idx==0); fis_last = (idx==4).
- Data stays stable until fis_ready. Index advances only when fis_valid && fis_ready.
- When DW4 is accepted, fis_valid drops in the following cycle and the state goes to WAIT_ACK.
- fis_ready held low stalls indefinitely; there is no timeout in SEND.

WAIT_ACK
- tx_ok → WAIT_D2H; the timeout counter clears.
- tx_err with retries < MAX_RETRIES → retries+1, idx=0, back to SEND with the same payload.
- tx_err with retries == MAX_RETRIES → DONE with cmd_error=1.
- If tx_ok and tx_err arrive in the same cycle, tx_err wins.

WAIT_D2H
- The timeout counter increments every cycle.
- d2h_stb with d2h_status[7] (BSY)=1 → latch cmd_status and cmd_error_reg, then keep waiting. Intermediate D2H FISes are permitted during a DMA data phase.
- d2h_stb with BSY=0 → latch both bytes; go to DONE with cmd_error = d2h_status[0].
- Counter reaching TIMEOUT_CYCLES-1 with no final D2H → DONE with cmd_error=1 and cmd_timeout=1.
- If d2h_stb arrives in the same cycle as the timeout, the D2H wins.

DONE
- One cycle: cmd_done=1 with cmd_error and cmd_timeout valid; then IDLE.
- cmd_status and cmd_error_reg hold until the next latch.
- The retry counter clears on return to IDLE.
- d2h_stb, tx_ok and tx_err are ignored outside their waiting states.

Test Plan:
1. Launch cmd 8'h25, lba 48'h0000_1234_5678, count 16'h0080, fis_ready=1 → fis_data sequence 32'h0025_8027, 32'h4034_5678, 32'h0000_0012, 32'h0000_0080, 32'h0; fis_first on dword 0, fis_last on dword 4. Then tx_ok, then d2h_status 8'h50 → cmd_done with cmd_error=0, cmd_status=8'h50.
2. Toggle fis_ready 1/0 each cycle during SEND → each dword is held stable while ready=0, no dword is skipped or duplicated, and 5 dwords are accepted in total.
3. tx_err 3 times then tx_ok (MAX_RETRIES=3) → 4 identical FIS transmissions, normal completion. Then tx_err 4 times → cmd_done with cmd_error=1 and no fifth retry.
4. After tx_ok, d2h_status 8'hD0 (BSY) then 8'h51 with d2h_error 8'h04 → busy is held after the first FIS; after the second, cmd_done with cmd_error=1, cmd_status=8'h51, cmd_error_reg=8'h04.
5. TIMEOUT_CYCLES=16 with no D2H → cmd_done 16 cycles after tx_ok with cmd_error=1 and cmd_timeout=1. A second strobe issued during busy is ignored; count 16'h0000 is sent as 0 in DW3.
6. Assert rst mid-SEND at dword 2 → all outputs are 0 asynchronously, no cmd_done. After release, a new command transmits from DW0.

Source files
------------

// File: rtl/sata_command_fis_tx_if.sv
// FIS dword stream from the command FIS builder to the SATA transport layer.
// The master drives one dword per transfer, marking the first and last dwords.
interface sata_command_fis_tx_if;
  logic [31:0] fis_data;
  logic        fis_valid;
  logic        fis_first;
  logic        fis_last;
  logic        fis_ready;

  modport master (output fis_data, output fis_valid, output fis_first,
                  output fis_last, input fis_ready);
  modport slave  (input fis_data, input fis_valid, input fis_first,
                  input fis_last, output fis_ready);
endinterface

// File: rtl/sata_command_fis_tx.sv
// Builds and sends a Register Host-to-Device FIS for each launched command.
// Retries on transport error, then waits for the final D2H status or a timeout.
module sata_command_fis_tx #(
  parameter logic [7:0]  DEVICE_REG     = 8'h40,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   sata_command,
  input  logic                         sata_execute_command_stb,
  input  logic [47:0]                  sata_lba,
  input  logic [15:0]                  sata_sector_count,
  output logic                         sata_busy,
  sata_command_fis_tx_if.master        fis,
  input  logic                         tx_ok,
  input  logic                         tx_err,
  input  logic                         d2h_stb,
  input  logic [7:0]                   d2h_status,
  input  logic [7:0]                   d2h_error,
  output logic                         cmd_done,
  output logic                         cmd_error,
  output logic                         cmd_timeout,
  output logic [7:0]                   cmd_status,
  output logic [7:0]                   cmd_error_reg
);

  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_D2H, DONE} state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [31:0]   timer_q, timer_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [47:0]   lba_q, lba_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    errreg_q, errreg_d;
  logic          err_q, err_d;
  logic          tmo_q, tmo_d;

  // NOTE: non-blocking assignments so every register updates from the same
  // pre-edge values. The payload registers are reset with the control state
  // so nothing depends on X-propagation after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      cmd_q    <= '0;
      lba_q    <= '0;
      cnt_q    <= '0;
      status_q <= '0;
      errreg_q <= '0;
      err_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      cmd_q    <= cmd_d;
      lba_q    <= lba_d;
      cnt_q    <= cnt_d;
      status_q <= status_d;
      errreg_q <= errreg_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  // NOTE: every variable gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    cmd_d    = cmd_q;
    lba_d    = lba_q;
    cnt_d    = cnt_q;
    status_d = status_q;
    errreg_d = errreg_q;
    err_d    = err_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (sata_execute_command_stb) begin
          cmd_d   = sata_command;
          lba_d   = sata_lba;
          cnt_d   = sata_sector_count;
          idx_d   = '0;
          err_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (fis.fis_ready) begin
          if (idx_q == 3'd4) begin
            idx_d   = '0;
            state_d = WAIT_ACK;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      WAIT_ACK: begin
        // tx_err takes priority over a coincident tx_ok.
        if (tx_err) begin
          if (retry_q < MAX_R) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else if (tx_ok) begin
          timer_d = '0;
          state_d = WAIT_D2H;
        end
      end
      WAIT_D2H: begin
        timer_d = timer_q + 32'd1;
        if (d2h_stb) begin
          status_d = d2h_status;
          errreg_d = d2h_error;
        end
        // A final (BSY=0) D2H beats a coincident timeout; a BSY=1 one does not.
        if (d2h_stb && !d2h_status[7]) begin
          err_d   = d2h_status[0];
          state_d = DONE;
        end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sata_busy     = (state_q == SEND) || (state_q == WAIT_ACK) || (state_q == WAIT_D2H);
    fis.fis_valid = (state_q == SEND);
    fis.fis_first = fis.fis_valid && (idx_q == 3'd0);
    fis.fis_last  = fis.fis_valid && (idx_q == 3'd4);
    fis.fis_data  = '0;
    if (fis.fis_valid) begin
      unique case (idx_q)
        3'd0:    fis.fis_data = {8'h00, cmd_q, 8'h80, 8'h27};
        3'd1:    fis.fis_data = {DEVICE_REG, lba_q[23:0]};
        3'd2:    fis.fis_data = {8'h00, lba_q[47:24]};
        3'd3:    fis.fis_data = {16'h0000, cnt_q};
        default: fis.fis_data = '0;
      endcase
    end
    cmd_done    = (state_q == DONE);
    cmd_error   = cmd_done && err_q;
    cmd_timeout = cmd_done && tmo_q;
  end

  assign cmd_status    = status_q;
  assign cmd_error_reg = errreg_q;

endmodule
